// File: rtl/neuron_state_sequencer.sv
// Per-time-step walker for the LIF accelerator: decays each stored potential, issues it with
// its weights, writes back the returned potential and forwards fired neuron IDs downstream.
//
// state   | meaning
// IDLE    | waiting for start; latches spikes and threshold
// FETCH   | weight read strobe for neuron idx
// ISSUE   | register weights, spikes, threshold and decayed potential into acc_*
// WAIT    | hold acc_* while the accelerator computes (ACC_LATENCY cycles)
// CAPTURE | write returned potential back, branch on spike
// EMIT    | present fired ID until accepted
// NEXT    | advance idx or finish
// DONE    | one-cycle done pulse
module neuron_state_sequencer #(
    parameter int NUM_NEURONS = 16,
    parameter int ADDR_W      = 4,
    parameter int DECAY_SHIFT = 1,
    parameter int ACC_LATENCY = 1
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic [3:0]         spike_in_vec_i,
    input  logic [31:0]        v_threshold_i,
    output logic               weight_rd_o,
    output logic [ADDR_W-1:0]  weight_addr_o,
    input  logic [127:0]       weight_data_i,
    output logic [3:0]         acc_spike_in_o,
    output logic [127:0]       acc_weight_o,
    output logic [31:0]        acc_v_threshold_o,
    output logic [31:0]        acc_decayed_potential_o,
    input  logic               acc_spiked_i,
    input  logic [31:0]        acc_potential_i,
    output logic               spike_out_valid_o,
    output logic [ADDR_W-1:0]  spike_out_id_o,
    input  logic               spike_out_ready_i,
    output logic               busy_o,
    output logic               done_o
);

    localparam int WAIT_W = (ACC_LATENCY > 1) ? $clog2(ACC_LATENCY) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(ACC_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_CAPTURE, S_EMIT, S_NEXT, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q;
    logic [WAIT_W-1:0]   wait_cnt_q;
    logic [3:0]          spikes_q;
    logic [31:0]         thr_q;
    logic [31:0]         pot_q [NUM_NEURONS];

    // A shift of zero makes v - v = 0, so no special case is needed.
    function automatic logic [31:0] decay(input logic [31:0] v);
        return v - (v >> DECAY_SHIFT);
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start_i) state_d = S_FETCH;
            S_FETCH:   state_d = S_ISSUE;
            S_ISSUE:   state_d = S_WAIT;
            S_WAIT:    if (wait_cnt_q == '0) state_d = S_CAPTURE;
            S_CAPTURE: state_d = acc_spiked_i ? S_EMIT : S_NEXT;
            S_EMIT:    if (spike_out_ready_i) state_d = S_NEXT;
            S_NEXT:    state_d = (idx_q == LAST_IDX) ? S_DONE : S_FETCH;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            idx_q                   <= '0;
            wait_cnt_q              <= '0;
            spikes_q                <= '0;
            thr_q                   <= '0;
            acc_spike_in_o          <= '0;
            acc_weight_o            <= '0;
            acc_v_threshold_o       <= '0;
            acc_decayed_potential_o <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) pot_q[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        spikes_q <= spike_in_vec_i;
                        thr_q    <= v_threshold_i;
                        idx_q    <= '0;
                    end
                end
                S_ISSUE: begin
                    acc_weight_o            <= weight_data_i;
                    acc_spike_in_o          <= spikes_q;
                    acc_v_threshold_o       <= thr_q;
                    acc_decayed_potential_o <= decay(pot_q[idx_q]);
                    wait_cnt_q              <= WAIT_LOAD;
                end
                S_WAIT:    if (wait_cnt_q != '0) wait_cnt_q <= wait_cnt_q - 1'b1;
                S_CAPTURE: pot_q[idx_q] <= acc_potential_i;
                S_NEXT:    if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
                default: ;
            endcase
        end
    end

    assign weight_addr_o = idx_q;

    always_comb begin
        weight_rd_o       = 1'b0;
        spike_out_valid_o = 1'b0;
        spike_out_id_o    = '0;
        done_o            = 1'b0;
        busy_o            = (state_q != S_IDLE);
        case (state_q)
            S_FETCH: weight_rd_o = 1'b1;
            S_EMIT: begin
                spike_out_valid_o = 1'b1;
                spike_out_id_o    = idx_q;
            end
            S_DONE:  done_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_neuron_state_sequencer.sv
// Bench for neuron_state_sequencer: an accelerator stand-in closes the loop, and a per-neuron
// potential model predicts decay, writeback, fired IDs and step length.
module tb_neuron_state_sequencer;
    localparam int NN = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n = 1'b0, start = 1'b0, start0 = 1'b0, spike_out_ready = 1'b0;
    logic [3:0]   spike_in_vec = '0;
    logic [31:0]  v_threshold = '0;

    logic         weight_rd, acc_spiked, spike_out_valid, busy, done;
    logic [3:0]   weight_addr, acc_spike_in, spike_out_id;
    logic [127:0] weight_data = '0, acc_weight;
    logic [31:0]  acc_v_threshold, acc_decayed, acc_potential;

    logic         weight_rd0, acc_spiked0, spike_out_valid0, busy0, done0;
    logic [3:0]   weight_addr0, acc_spike_in0, spike_out_id0;
    logic [127:0] weight_data0 = '0, acc_weight0;
    logic [31:0]  acc_v_threshold0, acc_decayed0, acc_potential0;

    logic [127:0] wmem [NN];
    logic [127:0] wmem0 [NN];
    logic [31:0]  ref_pot [NN];
    int checks = 0, errors = 0;

    neuron_state_sequencer dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .spike_in_vec_i(spike_in_vec),
        .v_threshold_i(v_threshold), .weight_rd_o(weight_rd), .weight_addr_o(weight_addr),
        .weight_data_i(weight_data), .acc_spike_in_o(acc_spike_in), .acc_weight_o(acc_weight),
        .acc_v_threshold_o(acc_v_threshold), .acc_decayed_potential_o(acc_decayed),
        .acc_spiked_i(acc_spiked), .acc_potential_i(acc_potential),
        .spike_out_valid_o(spike_out_valid), .spike_out_id_o(spike_out_id),
        .spike_out_ready_i(spike_out_ready), .busy_o(busy), .done_o(done));

    neuron_state_sequencer #(.DECAY_SHIFT(0)) dut0 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start0), .spike_in_vec_i(spike_in_vec),
        .v_threshold_i(v_threshold), .weight_rd_o(weight_rd0), .weight_addr_o(weight_addr0),
        .weight_data_i(weight_data0), .acc_spike_in_o(acc_spike_in0), .acc_weight_o(acc_weight0),
        .acc_v_threshold_o(acc_v_threshold0), .acc_decayed_potential_o(acc_decayed0),
        .acc_spiked_i(acc_spiked0), .acc_potential_i(acc_potential0),
        .spike_out_valid_o(spike_out_valid0), .spike_out_id_o(spike_out_id0),
        .spike_out_ready_i(1'b1), .busy_o(busy0), .done_o(done0));

    // Accelerator stand-in: integrate, fire at or above threshold, reset to zero on fire.
    function automatic logic [32:0] lif(input logic [3:0] s, input logic [127:0] w,
                                        input logic [31:0] thr, input logic [31:0] dec);
        logic [31:0] sum;
        sum = dec;
        for (int l = 0; l < 4; l++) if (s[l]) sum = sum + w[l*32 +: 32];
        if (sum >= thr) return {1'b1, 32'd0};
        return {1'b0, sum};
    endfunction

    assign {acc_spiked, acc_potential}   = lif(acc_spike_in, acc_weight, acc_v_threshold, acc_decayed);
    assign {acc_spiked0, acc_potential0} = lif(acc_spike_in0, acc_weight0, acc_v_threshold0, acc_decayed0);

    always @(posedge clk) begin
        if (weight_rd)  weight_data  <= wmem[weight_addr];
        if (weight_rd0) weight_data0 <= wmem0[weight_addr0];
    end

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < NN; n++) ref_pot[n] = '0;
    endtask

    // One time step with full monitoring. ready_mode: 0 always ready, 1 random, 2 stall first 10.
    task automatic run_step(input logic [3:0] sp, input logic [31:0] thr, input int ready_mode,
                            input bit noise, output int done_cyc, output int vcyc);
        logic [31:0] exp_dec [NN];
        logic [31:0] s;
        int exp_ids[$];
        int idx_exp = 0, cd = 0, pend = 0, cyc = 0;
        bit prev_stall = 0, got_done = 0;
        logic [3:0] prev_id = '0;
        logic r;
        for (int n = 0; n < NN; n++) begin
            exp_dec[n] = ref_pot[n] - ref_pot[n] / 2;
            s = exp_dec[n];
            for (int l = 0; l < 4; l++) if (sp[l]) s = s + wmem[n][l*32 +: 32];
            if (s >= thr) begin exp_ids.push_back(n); ref_pot[n] = '0; end
            else ref_pot[n] = s;
        end
        vcyc = 0; done_cyc = 0;
        spike_in_vec = sp; v_threshold = thr; start = 1'b1;
        while (!got_done && cyc < 600) begin
            @(negedge clk);
            cyc++;
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) begin spike_in_vec = 4'($urandom); v_threshold = $urandom; end
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL busy_in_step cyc=%0d got=%b want=1", cyc, busy); end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    checks++;
                    if (acc_decayed !== exp_dec[pend]) begin
                        errors++;
                        $display("FAIL decayed n=%0d got=%0d want=%0d", pend, acc_decayed, exp_dec[pend]);
                    end
                    checks++;
                    if (acc_weight !== wmem[pend] || acc_spike_in !== sp || acc_v_threshold !== thr) begin
                        errors++;
                        $display("FAIL acc_inputs n=%0d got w=%h s=%b t=%0d want w=%h s=%b t=%0d",
                                 pend, acc_weight, acc_spike_in, acc_v_threshold, wmem[pend], sp, thr);
                    end
                end
            end
            if (weight_rd) begin
                checks++;
                if (idx_exp >= NN || weight_addr !== 4'(idx_exp)) begin
                    errors++;
                    $display("FAIL weight_addr got=%0d want=%0d", weight_addr, idx_exp);
                end
                pend = idx_exp; idx_exp++; cd = 2;
            end
            if (prev_stall) begin
                checks++;
                if (spike_out_valid !== 1'b1 || spike_out_id !== prev_id) begin
                    errors++;
                    $display("FAIL emit_hold got v=%b id=%0d want v=1 id=%0d", spike_out_valid, spike_out_id, prev_id);
                end
            end
            prev_stall = 0;
            if (spike_out_valid === 1'b1) begin
                vcyc++;
                checks++;
                if (exp_ids.size() == 0 || spike_out_id !== 4'(exp_ids[0])) begin
                    errors++;
                    $display("FAIL spike_id got=%0d want=%0d", spike_out_id,
                             (exp_ids.size() == 0) ? -1 : exp_ids[0]);
                end
                case (ready_mode)
                    0:       r = 1'b1;
                    1:       r = 1'($urandom_range(0, 1));
                    default: r = (vcyc > 10);
                endcase
                spike_out_ready = r;
                if (r && exp_ids.size() != 0) void'(exp_ids.pop_front());
                prev_stall = !r;
                prev_id = spike_out_id;
            end else begin
                spike_out_ready = 1'($urandom_range(0, 1));
            end
            if (done === 1'b1) begin
                start = 1'b0;
                got_done = 1;
                done_cyc = cyc;
                checks++;
                if (cyc != 81 + vcyc || exp_ids.size() != 0 || idx_exp != NN) begin
                    errors++;
                    $display("FAIL done_timing got cyc=%0d left=%0d fetched=%0d want cyc=%0d left=0 fetched=16",
                             cyc, exp_ids.size(), idx_exp, 81 + vcyc);
                end
            end
        end
        if (!got_done) begin
            errors++;
            $display("FAIL step_timeout got no done within 600 cycles want done");
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL back_to_idle got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({weight_rd, spike_out_valid, busy, done, weight_addr, spike_out_id} !== '0 ||
            {acc_spike_in, acc_weight, acc_v_threshold, acc_decayed} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rd=%b v=%b busy=%b done=%b dec=%0d want all 0",
                     weight_rd, spike_out_valid, busy, done, acc_decayed);
        end
        rst_n = 1'b1;
        for (int n = 0; n < NN; n++) ref_pot[n] = '0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_first_step();
        int dc, vc;
        for (int n = 0; n < NN; n++) wmem[n] = {4{32'd10}};
        run_step(4'b0001, 32'd100, 0, 0, dc, vc);
        checks++;
        if (dc != 81 || vc != 0) begin
            errors++;
            $display("FAIL first_step got done=%0d emits=%0d want done=81 emits=0", dc, vc);
        end
        for (int n = 0; n < NN; n++) begin
            checks++;
            if (ref_pot[n] !== 32'd10) begin
                errors++;
                $display("FAIL model_first_wb n=%0d got=%0d want=10", n, ref_pot[n]);
            end
        end
    endtask

    task automatic test_repeat_steps();
        int dc, vc;
        for (int k = 0; k < 19; k++) run_step(4'b0001, 32'd100, 0, 0, dc, vc);
    endtask

    task automatic test_random_steps();
        int dc, vc;
        for (int k = 0; k < 10; k++) begin
            for (int n = 0; n < NN; n++)
                for (int l = 0; l < 4; l++) wmem[n][l*32 +: 32] = 32'($urandom_range(0, 60));
            run_step(4'($urandom), 32'($urandom_range(40, 250)), 1, 1, dc, vc);
        end
    endtask

    task automatic test_stall();
        int dc, vc;
        do_reset();
        for (int n = 0; n < NN; n++) wmem[n] = '0;
        wmem[3] = {4{32'd200}};
        run_step(4'b1111, 32'd100, 2, 0, dc, vc);
        checks++;
        if (dc != 92 || vc != 11) begin
            errors++;
            $display("FAIL stall got done=%0d valid_cycles=%0d want done=92 valid_cycles=11", dc, vc);
        end
    endtask

    task automatic test_reset_mid();
        int cd = 0, dc, vc;
        bit found = 0, seen_done = 0;
        for (int n = 0; n < NN; n++)
            for (int l = 0; l < 4; l++) wmem[n][l*32 +: 32] = 32'($urandom_range(1, 60));
        spike_in_vec = 4'hF; v_threshold = '1; start = 1'b1;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done === 1'b1) seen_done = 1;
            if (cd > 0) begin cd--; if (cd == 0) found = 1; end
            if (!found && weight_rd === 1'b1 && weight_addr === 4'd7) cd = 2;
        end
        checks++;
        if (!found || seen_done) begin
            errors++;
            $display("FAIL reach_wait7 got found=%b done_seen=%b want 1 0", found, seen_done);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({weight_rd, spike_out_valid, busy, done, weight_addr, spike_out_id} !== '0 ||
            {acc_spike_in, acc_weight, acc_v_threshold, acc_decayed} !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs got busy=%b done=%b addr=%0d dec=%0d want all 0",
                     busy, done, weight_addr, acc_decayed);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL no_done_after_reset got done=%b busy=%b want 0 0", done, busy);
            end
        end
        for (int n = 0; n < NN; n++) ref_pot[n] = '0;
        run_step(4'hF, 32'hFFFF_FFFF, 0, 0, dc, vc);
    endtask

    task automatic dz_step(input logic [31:0] w0, input logic [31:0] exp_pot);
        int cd = 0, k = 0;
        bit got = 0;
        for (int n = 0; n < NN; n++) wmem0[n] = {96'd0, w0};
        spike_in_vec = 4'b0001; v_threshold = '1; start0 = 1'b1;
        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk);
            start0 = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    k++;
                    checks++;
                    if (acc_decayed0 !== 32'd0 || acc_potential0 !== exp_pot) begin
                        errors++;
                        $display("FAIL decay_zero got dec=%0d wb=%0d want dec=0 wb=%0d",
                                 acc_decayed0, acc_potential0, exp_pot);
                    end
                end
            end
            if (weight_rd0 === 1'b1) cd = 2;
            if (done0 === 1'b1) got = 1;
        end
        checks++;
        if (!got || k != NN) begin
            errors++;
            $display("FAIL decay_zero_step got done=%b neurons=%0d want 1 16", got, k);
        end
        @(negedge clk);
    endtask

    task automatic test_decay_zero();
        dz_step(32'd50, 32'd50);
        dz_step(32'd0, 32'd0);
    endtask

    initial begin
        test_reset();
        test_first_step();
        test_repeat_steps();
        test_random_steps();
        test_stall();
        test_reset_mid();
        test_decay_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
